// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment driver for CPU LED/statistics values.
// Shows hex or zero-blanked decimal; each frame renders a latched snapshot.
module seg_scan_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_cpu_enable,
   input  logic [31:0] led_data_in,
   input  logic [31:0] total_cycles,
   input  logic [31:0] condi_branch_num,
   input  logic [31:0] uncondi_branch_num,
   input  logic [31:0] bubble_num,
   input  logic [2:0]  sel,
   input  logic        dec,
   input  logic        freeze,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        led_hit
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [4:0] BLANK = 5'd16;
   localparam logic [4:0] DASH  = 5'd17;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    idx, idx_nx;
   logic          tick, frame;
   logic [31:0]   snap, sh, bcd, adj, src;
   logic          mode, ovf, pend;
   logic [4:0]    n;
   logic [4:0]    digit [8];
   logic [4:0]    dec_code [8];
   logic          nz;

   function automatic logic [7:0] enc(input logic [4:0] c);
      logic [7:0] s;
      case (c)
         5'd0:  s = 8'hC0;
         5'd1:  s = 8'hF9;
         5'd2:  s = 8'hA4;
         5'd3:  s = 8'hB0;
         5'd4:  s = 8'h99;
         5'd5:  s = 8'h92;
         5'd6:  s = 8'h82;
         5'd7:  s = 8'hF8;
         5'd8:  s = 8'h80;
         5'd9:  s = 8'h90;
         5'd10: s = 8'h88;
         5'd11: s = 8'h83;
         5'd12: s = 8'hC6;
         5'd13: s = 8'hA1;
         5'd14: s = 8'h86;
         5'd15: s = 8'h8E;
         DASH:  s = 8'hBF;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign tick   = (cnt == CW'(SCAN_DIV - 1));
   assign frame  = tick && (idx == 3'd7);
   assign idx_nx = idx + 3'd1;

   always_comb begin
      case (sel)
         3'd1:    src = total_cycles;
         3'd2:    src = condi_branch_num;
         3'd3:    src = uncondi_branch_num;
         3'd4:    src = bubble_num;
         default: src = led_data_in;
      endcase
   end

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 8; i++)
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   always_comb begin
      nz = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         nz = nz | (bcd[4*i +: 4] != 4'd0);
         if (ovf)
            dec_code[i] = DASH;
         else if (!nz && i != 0)
            dec_code[i] = BLANK;
         else
            dec_code[i] = {1'b0, bcd[4*i +: 4]};
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pend && mode) state_nx = SHIFT;
         SHIFT:   if (n == 5'd31) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         idx  <= 3'd7;
         an   <= 8'hFF;
         seg  <= 8'hFF;
         snap <= '0;
         mode <= 1'b0;
         pend <= 1'b0;
      end else begin
         cnt  <= tick ? '0 : cnt + CW'(1);
         pend <= frame;
         if (tick) begin
            idx <= idx_nx;
            an  <= ~(8'd1 << idx_nx);
            seg <= enc(digit[idx_nx]);
         end
         if (frame && !freeze) begin
            snap <= src;
            mode <= dec;
         end
      end
   end

   // Refresh starts one cycle after the boundary so it sees the new snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh  <= '0;
         bcd <= '0;
         n   <= '0;
         ovf <= 1'b0;
         for (int i = 0; i < 8; i++) digit[i] <= '0;
      end else begin
         case (state)
            IDLE: if (pend) begin
               if (mode) begin
                  sh  <= snap;
                  bcd <= '0;
                  n   <= '0;
                  ovf <= 1'b0;
               end else begin
                  for (int i = 0; i < 8; i++)
                     digit[i] <= {1'b0, snap[4*i +: 4]};
               end
            end
            SHIFT: begin
               ovf <= ovf | adj[31];
               bcd <= {adj[30:0], sh[31]};
               sh  <= {sh[30:0], 1'b0};
               n   <= n + 5'd1;
            end
            DONE: begin
               for (int i = 0; i < 8; i++) digit[i] <= dec_code[i];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 led_hit <= 1'b0;
      else if (led_cpu_enable) led_hit <= 1'b1;
   end

endmodule
